// File: rtl/err_alarm_pkg.sv
// ----------------------------------------------------------------------------
// err_alarm_pkg
// Shared definitions for the error alarm controller slice.
//   alarm_state_t   : controller FSM states (IDLE, WATCH, ALARM)
//   DEF_WIN_LEN     : default window length in clock cycles
//   DEF_THRESH      : default number of events per window that raise the alarm
//   DEF_CNT_W       : default width of the lifetime error counter
//   winErrsWidth()  : width needed to hold 0..thresh window events
// ----------------------------------------------------------------------------
package err_alarm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WATCH = 2'd1,
      ALARM = 2'd2
   } alarm_state_t;

   localparam int DEF_WIN_LEN = 16;
   localparam int DEF_THRESH  = 4;
   localparam int DEF_CNT_W   = 8;

   // The window counter must hold every value from 0 up to and including
   // thresh, because the event that trips the alarm is still recorded.
   function automatic int winErrsWidth(input int thresh);
      int w;
      w = $clog2(thresh + 1);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rise_det.sv
// ----------------------------------------------------------------------------
// rise_det
// Registered rising-edge detector. The input is delayed by one flop and a
// rise is reported while the input is high and the delayed copy is low, so a
// multi-cycle high level produces exactly one single-cycle rise.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, loads RESET_VAL into the delay flop
//   i_d     : level to watch
//   o_rise  : high in the cycle where i_d is high and was low at the last edge
// With RESET_VAL = 0 an input already high when reset is released counts as a
// fresh rise.
// ----------------------------------------------------------------------------
module rise_det #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise
);

   logic r_dQ;

   // Delay flop holding the level seen at the previous edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dQ <= RESET_VAL;
      end else begin
         r_dQ <= i_d;
      end
   end

   assign o_rise = i_d & ~r_dQ;

endmodule

// File: rtl/err_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// err_alarm_ctrl
// Turns the pattern monitor's ERR level into discrete error events, keeps a
// saturating lifetime event count, remembers the Din value of the latest
// event and raises a sticky alarm when THRESH events land inside a window of
// WIN_LEN cycles that opens on the first event.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   ERR      : error level from the monitor; a high run is one event
//   Din      : monitor data, aligned with ERR
//   clr_ack  : single-cycle alarm acknowledge, ignored unless alarmed
//   alarm    : sticky alarm flag
//   err_cnt  : lifetime event count, saturating, cleared only by rst
//   last_din : Din captured at the most recent event
//   win_errs : events counted in the currently open window
// ----------------------------------------------------------------------------
module err_alarm_ctrl
   import err_alarm_pkg::*;
#(
   parameter int WIN_LEN = DEF_WIN_LEN,
   parameter int THRESH  = DEF_THRESH,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ERR,
   input  logic [2:0]                        Din,
   input  logic                              clr_ack,
   output logic                              alarm,
   output logic [CNT_W-1:0]                  err_cnt,
   output logic [2:0]                        last_din,
   output logic [winErrsWidth(THRESH)-1:0]   win_errs
);

   localparam int WE_W    = winErrsWidth(THRESH);
   localparam int TIMER_W = $clog2(WIN_LEN);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WIN_LEN - 1);
   localparam logic [WE_W-1:0]    THRESH_V   = WE_W'(THRESH);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

   // When a fresh window would open, a threshold of one means the opening
   // event is already enough to alarm.
   localparam alarm_state_t START_STATE = (THRESH == 1) ? ALARM : WATCH;

   alarm_state_t         r_state;
   alarm_state_t         w_nextState;
   logic [TIMER_W-1:0]   r_timer;
   logic [TIMER_W-1:0]   w_nextTimer;
   logic [TIMER_W-1:0]   w_timerInc;
   logic [WE_W-1:0]      r_winErrs;
   logic [WE_W-1:0]      w_nextWinErrs;
   logic [WE_W-1:0]      w_hits;
   logic [CNT_W-1:0]     r_errCnt;
   logic [2:0]           r_lastDin;
   logic                 r_alarm;
   logic                 w_event;

   rise_det #(
      .RESET_VAL (1'b0)
   ) uRiseDet (
      .clk    (clk),
      .rst    (rst),
      .i_d    (ERR),
      .o_rise (w_event)
   );

   assign w_timerInc = r_timer + TIMER_W'(1);
   assign w_hits     = r_winErrs + WE_W'(1);

   // Next-state logic. The timer holds the number of edges since the window
   // opened, so the incremented value tells whether this edge is the last one
   // of the window. An event on that last edge is still judged against the
   // threshold before the window is closed or restarted.
   always_comb begin
      w_nextState   = r_state;
      w_nextTimer   = r_timer;
      w_nextWinErrs = r_winErrs;
      case (r_state)
         IDLE: begin
            w_nextTimer = '0;
            if (w_event) begin
               w_nextState   = START_STATE;
               w_nextWinErrs = WE_W'(1);
            end
         end
         WATCH: begin
            w_nextTimer = w_timerInc;
            if (w_event && (w_hits >= THRESH_V)) begin
               w_nextState   = ALARM;
               w_nextWinErrs = w_hits;
            end else if (w_timerInc == TIMER_LAST) begin
               w_nextTimer = '0;
               if (w_event) begin
                  w_nextWinErrs = WE_W'(1);
               end else begin
                  w_nextState   = IDLE;
                  w_nextWinErrs = '0;
               end
            end else if (w_event) begin
               w_nextWinErrs = w_hits;
            end
         end
         ALARM: begin
            if (clr_ack) begin
               w_nextTimer = '0;
               if (w_event) begin
                  w_nextState   = START_STATE;
                  w_nextWinErrs = WE_W'(1);
               end else begin
                  w_nextState   = IDLE;
                  w_nextWinErrs = '0;
               end
            end
         end
         default: begin
            w_nextState   = IDLE;
            w_nextTimer   = '0;
            w_nextWinErrs = '0;
         end
      endcase
   end

   // State, window and output registers. The alarm flop is loaded from the
   // next state so it rises on the edge that sees the tripping event and
   // falls on the edge that sees the acknowledge. The lifetime counter and
   // captured Din keep updating while alarmed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_winErrs <= '0;
         r_errCnt  <= '0;
         r_lastDin <= 3'b000;
         r_alarm   <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_timer   <= w_nextTimer;
         r_winErrs <= w_nextWinErrs;
         r_alarm   <= (w_nextState == ALARM);
         if (w_event) begin
            r_lastDin <= Din;
            if (r_errCnt != CNT_MAX) begin
               r_errCnt <= r_errCnt + CNT_W'(1);
            end
         end
      end
   end

   assign alarm    = r_alarm;
   assign err_cnt  = r_errCnt;
   assign last_din = r_lastDin;
   assign win_errs = r_winErrs;

endmodule

// File: doc/err_alarm_ctrl.md
# err_alarm_ctrl

Downstream consumer of the 3-bit pattern monitor's `ERR` output. Converts raw `ERR` activity into discrete error events, keeps a saturating lifetime error count, and captures the last offending `Din`. It raises a sticky `alarm` when `THRESH` events occur within a sliding-start window of `WIN_LEN` cycles. The alarm holds until software acknowledges it with `clr_ack`.

## Interface
Parameters:
- `WIN_LEN`, 16: window length in clock cycles (≥2).
- `THRESH`, 4: events per window that trigger the alarm (1..WIN_LEN).
- `CNT_W`, 8: width of the lifetime error counter.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `ERR`, in, 1: error flag from the monitor stage; may stay high for several cycles.
- `Din`, in, 3: the monitor's data input, aligned with `ERR`.
- `clr_ack`, in, 1: alarm acknowledge, single-cycle pulse.
- `alarm`, out, 1: sticky alarm.
- `err_cnt`, out, CNT_W: lifetime count of error events, saturating.
- `last_din`, out, 3: `Din` sampled at the most recent error event.
- `win_errs`, out, $clog2(THRESH+1): number of events in the current window.

## Operation
- Event definition:
  - `ev = ERR & ~err_q`, where `err_q` is `ERR` registered.
  - A multi-cycle `ERR` high level counts as one event.
  - `err_q` resets to 0, so `ERR` high in the first cycle after reset counts as an event.
- On every event:
  - `last_din <= Din`.
  - `err_cnt <= err_cnt + 1`, saturating at 2^CNT_W−1. It never wraps and is cleared only by `rst`.
- FSM states: IDLE, WATCH, ALARM.
  - IDLE:
    - Event with THRESH==1 → ALARM.
    - Any other event → WATCH, with `timer=0` and `win_errs=1`.
  - WATCH: `timer` increments each cycle. For each event, `hits = win_errs+1`.
    - Event and `hits>=THRESH` → ALARM.
    - Else, `timer==WIN_LEN-1`:
      - With an event → restart the window: `timer=0`, `win_errs=1`, stay in WATCH.
      - With no event → IDLE, `win_errs=0`.
    - Else, event → `win_errs=hits`.
  - ALARM: `alarm=1`. Events still update `err_cnt` and `last_din`; `win_errs` is frozen.
    - `clr_ack` with no event → IDLE, `win_errs=0`.
    - `clr_ack` with an event → same as an IDLE event: WATCH with `win_errs=1`, or ALARM again if THRESH==1.
- `clr_ack` outside ALARM is ignored.
- Reset mid-operation:
  - All state returns to the reset values on the next edge.
  - An `ERR` high level still present after reset counts as one new event.

## Timing
- Reset values:
  - `alarm=0`, `err_cnt=0`, `last_din=3'b000`, `win_errs=0`.
  - State IDLE, `timer=0`, `err_q=0`.
- All outputs are registered.
- `ERR` rising at edge N is detected at edge N. `err_cnt`, `last_din` and `win_errs` update at edge N and are visible after it.
- `alarm` rises at the same edge that samples the THRESH-th event, so it is visible one cycle after `ERR` is driven.
- `alarm` falls at the edge that samples `clr_ack`.
- Window span: the first event's edge plus WIN_LEN−1 further edges. An event on the last of these edges still counts toward the threshold.

## Structure
- Package `err_alarm_pkg`:
  - State enum `alarm_state_t` (IDLE, WATCH, ALARM).
  - Default parameter constants.
  - Width helper for `win_errs`.
- Sub-module `rise_det`: registered rising-edge detector, parameterised on reset value.
- Top level holds the FSM, the window timer and the counters.

## Test plan
- Reset: hold `rst` for 3 cycles with `ERR=1` → all outputs 0. On the first cycle with `rst=0`, `err_cnt=1`.
- `ERR` high for 3 cycles once, `Din=3'b111` → `err_cnt=1`, `last_din=111`, `win_errs=1`, `alarm=0`.
- Drive 4 pulses 3 cycles apart (each high 1 cycle, `Din` 101, 110, 011, 111) → `alarm=1` at the 4th pulse's edge, `last_din=111`, `err_cnt=4`. Further pulses keep `alarm=1` and give `err_cnt=5`.
- Drive 3 pulses within 6 cycles, wait ≥16 cycles from the first, then 1 pulse → `alarm` stays 0; `win_errs` goes 3→0→1.
- In ALARM, drive `clr_ack` and an `ERR` rise in the same cycle → `alarm=0` next cycle, state WATCH, `win_errs=1`, `err_cnt` incremented.
- With CNT_W=4, drive 20 isolated pulses with `clr_ack` after each alarm → `err_cnt` stops at 15. Assert `rst` mid-WATCH → next cycle all outputs are 0.
